// File: rtl/count_seq_pkg.sv
// Shared types and defaults for the counter-sequence source.
package count_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } cs_state_e;

  localparam int CS_DEFAULT_W = 4;

endpackage : count_seq_pkg

// File: rtl/count_seq_gen.sv
// Counter-sequence source: on start, emits 1..limit over a valid/ready
// stream, then pulses done for one cycle and returns to idle.
// All outputs are registered; no input reaches an output combinationally.
// Optional feature: define COUNT_SEQ_GEN_PAUSE_EN to add the pause input,
// which withholds the next beat (never a beat already presented).
module count_seq_gen
  import count_seq_pkg::*;
#(
  parameter int W = CS_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] limit,
  output logic         cnt_valid,
  output logic [W-1:0] cnt_data,
  input  logic         cnt_ready,
  output logic         busy,
  output logic         done
`ifdef COUNT_SEQ_GEN_PAUSE_EN
  ,
  input  logic         pause
`endif
);

  cs_state_e    state_q, state_d;
  logic [W-1:0] lim_q, lim_d;
  logic [W-1:0] cnt_d;
  logic         valid_d;
  logic         busy_d;
  logic         done_d;
  logic         pause_in;
  logic         xfer;

`ifdef COUNT_SEQ_GEN_PAUSE_EN
  assign pause_in = pause;
`else
  assign pause_in = 1'b0;
`endif

  assign xfer = cnt_valid & cnt_ready;

  // Next-state, next-count and next-output decode.
  // busy/done are derived from the next state so they can be registered
  // and still line up with the state they describe.
  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    cnt_d   = cnt_data;
    valid_d = cnt_valid;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          lim_d = limit;
          if (limit != '0) begin
            state_d = S_RUN;
            cnt_d   = W'(1);
            valid_d = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (cnt_data == lim_q) begin
            valid_d = 1'b0;
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_data + W'(1);
            valid_d = ~pause_in;
          end
        end else if (!cnt_valid) begin
          // Withheld beat: cnt_data already holds the next value.
          valid_d = ~pause_in;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, count, limit and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lim_q     <= '0;
      cnt_data  <= '0;
      cnt_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lim_q     <= lim_d;
      cnt_data  <= cnt_d;
      cnt_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule : count_seq_gen
